// File: rtl/mux_stream_arb.sv
// mux_stream_arb
//   Registered N-channel stream multiplexer with a valid/ready handshake.
//   One input channel is granted per cycle. The grant comes either from an
//   external select or from a round-robin search. The granted word goes
//   through a single output register that feeds one downstream consumer.
//
// Parameters
//   NCH   number of input channels (>= 1)
//   DW    data width per channel
//   SELW  channel-index width, derived from NCH; do not override
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active low
//   mode       0 = external select, 1 = round-robin
//   sel        channel index used when mode = 0
//   in_valid   per-channel valid
//   in_data    channel i occupies bits [i*DW +: DW]
//   in_ready   per-channel ready, one-hot or zero, combinational
//   out_valid  output word valid
//   out_data   output word
//   out_ch     source channel of out_data
//   out_ready  downstream ready
//   xfer_cnt   16-bit count of output handshakes, wraps; present only
//              when MUX_XFER_CNT_EN is defined
//
// Optional feature macro: MUX_XFER_CNT_EN

module mux_stream_arb #(
  parameter int NCH  = 4,
  parameter int DW   = 8,
  parameter int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic [NCH-1:0]    in_valid,
  input  logic [NCH*DW-1:0] in_data,
  output logic [NCH-1:0]    in_ready,
  output logic              out_valid,
  output logic [DW-1:0]     out_data,
  output logic [SELW-1:0]   out_ch,
  input  logic              out_ready
`ifdef MUX_XFER_CNT_EN
  ,
  output logic [15:0]       xfer_cnt
`endif
);

  // One spare bit so that rr_ptr + offset can be formed without overflow
  // before the modulo-NCH fold.
  localparam int SW1 = SELW + 1;

  logic            out_valid_reg;
  logic [DW-1:0]   out_data_reg;
  logic [SELW-1:0] out_ch_reg;
  logic [SELW-1:0] rr_ptr_reg;

  logic            load_en;
  logic            gnt_any;
  logic [SELW-1:0] gnt_idx;
  logic [SW1-1:0]  cand;
  logic [NCH-1:0]  grant;
  logic [DW-1:0]   ch_data [NCH];

  // While reset is held, no input may be accepted. Gating the load
  // enable here forces every in_ready low.
  assign load_en = rst_n && (!out_valid_reg || out_ready);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      assign ch_data[gi]  = in_data[gi*DW +: DW];
      assign grant[gi]    = gnt_any && (gnt_idx == SELW'(gi));
      assign in_ready[gi] = load_en && grant[gi];
    end
  endgenerate

  // Grant selection. With a single channel, both mode and sel are ignored.
  // In round-robin mode, the search begins at rr_ptr and the first valid
  // channel in cyclic order wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (NCH == 1) begin
      gnt_any = in_valid[0];
    end else if (!mode) begin
      if ({1'b0, sel} < SW1'(NCH)) begin
        gnt_any = in_valid[sel];
        gnt_idx = sel;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        cand = {1'b0, rr_ptr_reg} + SW1'(k);
        // Both rr_ptr and k are below NCH, so one subtraction gives mod NCH.
        if (cand >= SW1'(NCH)) begin
          cand = cand - SW1'(NCH);
        end
        if (!gnt_any && in_valid[cand[SELW-1:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = cand[SELW-1:0];
        end
      end
    end
  end

  // Output register and round-robin pointer. When the slot is free and
  // nothing is granted, the register empties. The old data and channel
  // are kept so that out_data and out_ch do not toggle for no reason.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      rr_ptr_reg    <= '0;
    end else if (load_en) begin
      if (gnt_any) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= ch_data[gnt_idx];
        out_ch_reg    <= gnt_idx;
        if (mode && (NCH > 1)) begin
          rr_ptr_reg <= (gnt_idx == SELW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;

`ifdef MUX_XFER_CNT_EN
  logic [15:0] xfer_cnt_reg;

  // This counter wraps from 16'hFFFF to 0 by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_reg <= '0;
    end else if (out_valid_reg && out_ready) begin
      xfer_cnt_reg <= xfer_cnt_reg + 16'd1;
    end
  end

  assign xfer_cnt = xfer_cnt_reg;
`endif

endmodule
